// File: rtl/srio_udp_pkg.sv
// Shared types, limits and helpers for the SRIO-to-UDP receive path.
package srio_udp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_HI,
      ST_LO,
      ST_DROP
   } state_e;

   localparam logic [15:0] MAX_LEN_DEF = 16'd1472;
   localparam logic [15:0] MIN_LEN_DEF = 16'd1;

   // Bits [63:32] of an SRIO beat leave the block before bits [31:0].
   localparam bit UPPER_WORD_FIRST = 1'b1;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/srio2udp_width_conv.sv
// 64-bit beat holding register that replays a beat as one or two 32-bit words.
module srio2udp_width_conv
   import srio_udp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        load_first,
   input  logic [63:0] beat_data,
   input  logic [7:0]  beat_keep,
   input  logic        beat_last,
   input  logic        udp_ready,
   output logic [31:0] udp_data,
   output logic [3:0]  udp_keep,
   output logic        udp_valid,
   output logic        udp_first,
   output logic        udp_last,
   output logic        beat_end,
   output logic        pkt_end,
   output logic        lo_next
);

   logic [63:0] data_q, data_d;
   logic [7:0]  keep_q, keep_d;
   logic        last_q, last_d;
   logic        first_q, first_d;
   logic        valid_q, valid_d;
   logic        lo_q, lo_d;

   logic [31:0] word_a, word_b;
   logic [3:0]  keep_a, keep_b;
   logic        xfer, final_half;

   always_comb begin
      word_a = UPPER_WORD_FIRST ? data_q[63:32] : data_q[31:0];
      word_b = UPPER_WORD_FIRST ? data_q[31:0]  : data_q[63:32];
      keep_a = UPPER_WORD_FIRST ? keep_q[7:4]   : keep_q[3:0];
      keep_b = UPPER_WORD_FIRST ? keep_q[3:0]   : keep_q[7:4];

      // A beat whose second half carries no bytes ends on its first word.
      final_half = lo_q | (keep_b == 4'd0);
      xfer       = valid_q & udp_ready;
      beat_end   = xfer & final_half;
      pkt_end    = beat_end & last_q;

      udp_data  = lo_q ? word_b : word_a;
      udp_keep  = lo_q ? keep_b : keep_a;
      udp_valid = valid_q;
      udp_first = first_q;
      udp_last  = last_q & final_half;

      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      first_d = first_q;
      valid_d = valid_q;
      lo_d    = lo_q;

      if (xfer) begin
         first_d = 1'b0;
         if (final_half) begin
            valid_d = 1'b0;
            lo_d    = 1'b0;
         end else begin
            lo_d = 1'b1;
         end
      end

      if (load) begin
         data_d  = beat_data;
         keep_d  = beat_keep;
         last_d  = beat_last;
         first_d = load_first;
         valid_d = 1'b1;
         lo_d    = 1'b0;
      end

      lo_next = lo_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         first_q <= 1'b0;
         valid_q <= 1'b0;
         lo_q    <= 1'b0;
      end else begin
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         first_q <= first_d;
         valid_q <= valid_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: rtl/srio2udp_interface.sv
// SRIO receive stream (64-bit) to UDP transmit stream (32-bit) with arbitration,
// length screening and byte-count checking.
module srio2udp_interface
   import srio_udp_pkg::*;
#(
   parameter logic [15:0] MAX_LEN = MAX_LEN_DEF,
   parameter logic [15:0] MIN_LEN = MIN_LEN_DEF
)(
   input  logic        clk_udp,
   input  logic        reset_udp,
   input  logic [63:0] srio_data_in,
   input  logic        srio_valid_in,
   input  logic        srio_first_in,
   input  logic        srio_last_in,
   input  logic [7:0]  srio_keep_in,
   input  logic [15:0] srio_length_in,
   output logic        srio_ready_out,
   output logic        udp_req_out,
   input  logic        udp_ack_in,
   output logic [31:0] udp_data_out,
   output logic        udp_valid_out,
   output logic        udp_first_out,
   output logic        udp_last_out,
   output logic [3:0]  udp_keep_out,
   output logic [15:0] udp_length_out,
   input  logic        udp_ready_in,
   output logic        pkt_done_out,
   output logic        len_err_out
);

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        load, load_first;
   logic        conv_valid, conv_beat_end, conv_pkt_end, conv_lo_next;
   logic [15:0] beat_bytes;

   assign beat_bytes = {12'd0, popcount8(srio_keep_in)};

   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      cnt_d          = cnt_q;
      req_d          = req_q;
      done_d         = 1'b0;
      err_d          = 1'b0;
      srio_ready_out = 1'b0;
      load           = 1'b0;
      load_first     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The first beat stays on the bus until the grant arrives.
            if (srio_valid_in && srio_first_in) begin
               if (srio_length_in < MIN_LEN || srio_length_in > MAX_LEN) begin
                  err_d   = 1'b1;
                  state_d = ST_DROP;
               end else begin
                  len_d   = srio_length_in;
                  req_d   = 1'b1;
                  state_d = ST_REQ;
               end
            end else if (srio_valid_in) begin
               srio_ready_out = 1'b1;
            end
         end
         ST_REQ: begin
            if (udp_ack_in) begin
               req_d          = 1'b0;
               srio_ready_out = 1'b1;
               load           = 1'b1;
               load_first     = 1'b1;
               cnt_d          = beat_bytes;
               state_d        = ST_HI;
            end
         end
         ST_HI, ST_LO: begin
            if (conv_pkt_end) begin
               done_d  = 1'b1;
               err_d   = (cnt_q != len_q);
               state_d = ST_IDLE;
            end else if (conv_beat_end || !conv_valid) begin
               // Refill in the same cycle the held beat drains: no bubble.
               srio_ready_out = 1'b1;
               state_d        = ST_HI;
               if (srio_valid_in) begin
                  load  = 1'b1;
                  cnt_d = cnt_q + beat_bytes;
                  err_d = srio_first_in;
               end
            end else begin
               state_d = conv_lo_next ? ST_LO : ST_HI;
            end
         end
         ST_DROP: begin
            srio_ready_out = 1'b1;
            if (srio_valid_in && srio_last_in) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_udp or posedge reset_udp) begin
      if (reset_udp) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign udp_req_out    = req_q;
   assign udp_length_out = len_q;
   assign pkt_done_out   = done_q;
   assign len_err_out    = err_q;

   srio2udp_width_conv u_conv (
      .clk        (clk_udp),
      .rst        (reset_udp),
      .load       (load),
      .load_first (load_first),
      .beat_data  (srio_data_in),
      .beat_keep  (srio_keep_in),
      .beat_last  (srio_last_in),
      .udp_ready  (udp_ready_in),
      .udp_data   (udp_data_out),
      .udp_keep   (udp_keep_out),
      .udp_valid  (conv_valid),
      .udp_first  (udp_first_out),
      .udp_last   (udp_last_out),
      .beat_end   (conv_beat_end),
      .pkt_end    (conv_pkt_end),
      .lo_next    (conv_lo_next)
   );

   assign udp_valid_out = conv_valid;

endmodule

// File: tb/tb_srio2udp_interface.sv
// Scoreboard bench for srio2udp_interface: directed packets, expected words queued at issue.
module tb_srio2udp_interface;

   logic        clk_udp = 1'b0;
   logic        reset_udp;
   logic [63:0] srio_data_in;
   logic        srio_valid_in, srio_first_in, srio_last_in;
   logic [7:0]  srio_keep_in;
   logic [15:0] srio_length_in;
   logic        srio_ready_out;
   logic        udp_req_out;
   logic        udp_ack_in;
   logic [31:0] udp_data_out;
   logic        udp_valid_out, udp_first_out, udp_last_out;
   logic [3:0]  udp_keep_out;
   logic [15:0] udp_length_out;
   logic        udp_ready_in;
   logic        pkt_done_out, len_err_out;

   always #5 clk_udp = ~clk_udp;

   srio2udp_interface dut (
      .clk_udp        (clk_udp),
      .reset_udp      (reset_udp),
      .srio_data_in   (srio_data_in),
      .srio_valid_in  (srio_valid_in),
      .srio_first_in  (srio_first_in),
      .srio_last_in   (srio_last_in),
      .srio_keep_in   (srio_keep_in),
      .srio_length_in (srio_length_in),
      .srio_ready_out (srio_ready_out),
      .udp_req_out    (udp_req_out),
      .udp_ack_in     (udp_ack_in),
      .udp_data_out   (udp_data_out),
      .udp_valid_out  (udp_valid_out),
      .udp_first_out  (udp_first_out),
      .udp_last_out   (udp_last_out),
      .udp_keep_out   (udp_keep_out),
      .udp_length_out (udp_length_out),
      .udp_ready_in   (udp_ready_in),
      .pkt_done_out   (pkt_done_out),
      .len_err_out    (len_err_out)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        first;
      logic        last;
      logic [15:0] len;
   } word_t;

   word_t       wq[$];
   logic [1:0]  evq[$];
   int          tests = 0;
   int          fails = 0;
   bit          mon_en = 1'b0;
   bit          no_req = 1'b0;
   bit          rand_ready = 1'b0;
   logic [63:0] bd[8];
   logic [7:0]  bk[8];

   word_t       mon_cur, mon_exp, stall_w;
   bit          stalled = 1'b0;
   logic [1:0]  ev_exp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic word_t mkw(input logic [31:0] d, input logic [3:0] k,
                                 input logic f, input logic l, input logic [15:0] len);
      word_t w;
      w.data = d; w.keep = k; w.first = f; w.last = l; w.len = len;
      return w;
   endfunction

   // Expected words straight from the stream definition: upper half, then lower half if any bytes.
   task automatic push_beats(input logic [15:0] len, input int nb);
      for (int i = 0; i < nb; i++) begin
         wq.push_back(mkw(bd[i][63:32], bk[i][7:4], i == 0,
                          (i == nb - 1) && (bk[i][3:0] == 4'h0), len));
         if (bk[i][3:0] != 4'h0)
            wq.push_back(mkw(bd[i][31:0], bk[i][3:0], 1'b0, i == nb - 1, len));
      end
   endtask

   // Downstream ready: always-on or coin-flip.
   initial begin
      udp_ready_in = 1'b1;
      forever begin
         @(posedge clk_udp); #1;
         udp_ready_in = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
      end
   end

   // Arbiter: grant one cycle after a request is seen, as a single-cycle pulse.
   initial begin
      udp_ack_in = 1'b0;
      forever begin
         @(posedge clk_udp); #1;
         if (udp_ack_in) udp_ack_in = 1'b0;
         else if (udp_req_out) udp_ack_in = 1'b1;
      end
   end

   // Monitor: compares accepted words, hold stability and status pulses.
   initial begin
      forever begin
         @(negedge clk_udp);
         if (!mon_en) begin
            stalled = 1'b0;
         end else begin
            mon_cur = {udp_data_out, udp_keep_out, udp_first_out, udp_last_out, udp_length_out};
            if (stalled)
               check("hold_stable", {9'd0, udp_valid_out, mon_cur}, {9'd0, 1'b1, stall_w});
            if (udp_valid_out && udp_ready_in) begin
               if (wq.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_word: got %h expected none", mon_cur);
               end else begin
                  mon_exp = wq.pop_front();
                  check("word", {10'd0, mon_cur}, {10'd0, mon_exp});
               end
            end
            stalled = udp_valid_out && !udp_ready_in;
            stall_w = mon_cur;
            if (pkt_done_out || len_err_out) begin
               if (evq.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_pulse: got done=%b err=%b expected none",
                           pkt_done_out, len_err_out);
               end else begin
                  ev_exp = evq.pop_front();
                  check("done_err", {62'd0, pkt_done_out, len_err_out}, {62'd0, ev_exp});
               end
            end
            if (no_req) check("req_in_drop", {63'd0, udp_req_out}, 64'd0);
         end
      end
   end

   task automatic wait_accept();
      int  n;
      bit  acc;
      n = 0; acc = 1'b0;
      while (!acc && n < 300) begin
         @(negedge clk_udp);
         acc = srio_ready_out;
         @(posedge clk_udp); #1;
         n++;
      end
      if (!acc) begin
         tests++; fails++;
         $display("FAIL beat_accept: got timeout expected accept within 300 cycles");
      end
   endtask

   task automatic send_pkt(input logic [15:0] len, input int nb);
      for (int i = 0; i < nb; i++) begin
         srio_valid_in  = 1'b1;
         srio_first_in  = (i == 0);
         srio_last_in   = (i == nb - 1);
         srio_data_in   = bd[i];
         srio_keep_in   = bk[i];
         srio_length_in = (i == 0) ? len : 16'h0;
         wait_accept();
      end
      srio_valid_in = 1'b0; srio_first_in = 1'b0; srio_last_in = 1'b0;
      srio_data_in = '0; srio_keep_in = '0; srio_length_in = '0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((wq.size() != 0 || evq.size() != 0) && n < 500) begin
         @(posedge clk_udp); #1;
         n++;
      end
      check(name, 64'(wq.size() + evq.size()), 64'd0);
      repeat (2) @(posedge clk_udp);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      return {5'd0, srio_ready_out, udp_req_out, udp_data_out, udp_valid_out, udp_first_out,
              udp_last_out, udp_keep_out, udp_length_out, pkt_done_out, len_err_out};
   endfunction

   int n_wait;

   initial begin
      reset_udp = 1'b1;
      srio_valid_in = 1'b0; srio_first_in = 1'b0; srio_last_in = 1'b0;
      srio_data_in = '0; srio_keep_in = '0; srio_length_in = '0;
      repeat (3) @(posedge clk_udp);
      #1;
      check("reset_outputs", all_outs(), 64'd0);
      reset_udp = 1'b0;
      @(posedge clk_udp); #1;
      check("idle_outputs", all_outs(), 64'd0);
      mon_en = 1'b1;

      // Two full beats, length 16.
      bd[0] = 64'h0011223344556677; bk[0] = 8'hFF;
      bd[1] = 64'h8899AABBCCDDEEFF; bk[1] = 8'hFF;
      wq.push_back(mkw(32'h00112233, 4'hF, 1'b1, 1'b0, 16'd16));
      wq.push_back(mkw(32'h44556677, 4'hF, 1'b0, 1'b0, 16'd16));
      wq.push_back(mkw(32'h8899AABB, 4'hF, 1'b0, 1'b0, 16'd16));
      wq.push_back(mkw(32'hCCDDEEFF, 4'hF, 1'b0, 1'b1, 16'd16));
      evq.push_back(2'b10);
      send_pkt(16'd16, 2);
      drain("drain_full16");

      // Length 12, final beat upper half only.
      bk[1] = 8'hF0;
      wq.push_back(mkw(32'h00112233, 4'hF, 1'b1, 1'b0, 16'd12));
      wq.push_back(mkw(32'h44556677, 4'hF, 1'b0, 1'b0, 16'd12));
      wq.push_back(mkw(32'h8899AABB, 4'hF, 1'b0, 1'b1, 16'd12));
      evq.push_back(2'b10);
      send_pkt(16'd12, 2);
      drain("drain_partial12");

      // Stray beat without first in IDLE is consumed and discarded.
      srio_valid_in = 1'b1; srio_data_in = 64'hBADBADBADBADBAD0; srio_keep_in = 8'hFF;
      @(negedge clk_udp);
      check("stray_ready", {63'd0, srio_ready_out}, 64'd1);
      @(posedge clk_udp); #1;
      srio_valid_in = 1'b0; srio_data_in = '0; srio_keep_in = '0;

      // Oversize length: dropped, no request.
      bd[0] = 64'h1010101010101010; bk[0] = 8'hFF;
      bd[1] = 64'h2020202020202020; bk[1] = 8'hFF;
      bd[2] = 64'h3030303030303030; bk[2] = 8'hFF;
      no_req = 1'b1;
      evq.push_back(2'b01);
      send_pkt(16'd2000, 3);
      drain("drain_drop");
      no_req = 1'b0;

      // Next legal packet after the drop.
      bd[0] = 64'hDEADBEEFCAFEF00D; bk[0] = 8'hFF;
      wq.push_back(mkw(32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 16'd8));
      wq.push_back(mkw(32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 16'd8));
      evq.push_back(2'b10);
      send_pkt(16'd8, 1);
      drain("drain_after_drop");

      // Declared 24, only 16 bytes sent: forwarded, done and err together.
      bd[0] = 64'h0102030405060708; bk[0] = 8'hFF;
      bd[1] = 64'h090A0B0C0D0E0F10; bk[1] = 8'hFF;
      wq.push_back(mkw(32'h01020304, 4'hF, 1'b1, 1'b0, 16'd24));
      wq.push_back(mkw(32'h05060708, 4'hF, 1'b0, 1'b0, 16'd24));
      wq.push_back(mkw(32'h090A0B0C, 4'hF, 1'b0, 1'b0, 16'd24));
      wq.push_back(mkw(32'h0D0E0F10, 4'hF, 1'b0, 1'b1, 16'd24));
      evq.push_back(2'b11);
      send_pkt(16'd24, 2);
      drain("drain_short");

      // Single beat, upper half only: one word, first and last.
      bd[0] = 64'hA1B2C3D4E5F60718; bk[0] = 8'hF0;
      wq.push_back(mkw(32'hA1B2C3D4, 4'hF, 1'b1, 1'b1, 16'd4));
      evq.push_back(2'b10);
      send_pkt(16'd4, 1);
      drain("drain_single");

      // Random backpressure over two packets.
      rand_ready = 1'b1;
      bd[0] = 64'h1122334455667788; bk[0] = 8'hFF;
      bd[1] = 64'h99AABBCCDDEEFF00; bk[1] = 8'hFF;
      bd[2] = 64'h0F1E2D3C4B5A6978; bk[2] = 8'hFF;
      bd[3] = 64'h8796A5B4C3D2E1F0; bk[3] = 8'hF0;
      push_beats(16'd28, 4);
      evq.push_back(2'b10);
      send_pkt(16'd28, 4);
      bd[0] = 64'hFEDCBA9876543210; bk[0] = 8'hFF;
      bd[1] = 64'h0123456789ABCDEF; bk[1] = 8'hFF;
      bd[2] = 64'h5555AAAA3333CCCC; bk[2] = 8'hFF;
      push_beats(16'd24, 3);
      evq.push_back(2'b10);
      send_pkt(16'd24, 3);
      drain("drain_backpressure");
      rand_ready = 1'b0;
      @(posedge clk_udp); #1;

      // Reset while the lower half of a beat is on the output.
      mon_en = 1'b0;
      srio_valid_in = 1'b1; srio_first_in = 1'b1; srio_last_in = 1'b0;
      srio_data_in = 64'h1111111122222222; srio_keep_in = 8'hFF; srio_length_in = 16'd16;
      n_wait = 0;
      do begin
         @(negedge clk_udp);
         n_wait++;
      end while (!(udp_valid_out && udp_first_out) && n_wait < 50);
      check("reach_hi_word", {63'd0, udp_valid_out && udp_first_out}, 64'd1);
      @(posedge clk_udp); #1;
      check("lo_word_before_reset", {32'd0, udp_data_out}, 64'h22222222);
      reset_udp = 1'b1;
      srio_valid_in = 1'b0; srio_first_in = 1'b0;
      srio_data_in = '0; srio_keep_in = '0; srio_length_in = '0;
      #1;
      check("midpkt_reset_outputs", all_outs(), 64'd0);
      @(posedge clk_udp); #1;
      check("midpkt_reset_hold", all_outs(), 64'd0);
      reset_udp = 1'b0;
      wq.delete(); evq.delete();
      @(posedge clk_udp); #1;
      mon_en = 1'b1;

      bd[0] = 64'h7777666655554444; bk[0] = 8'hFF;
      wq.push_back(mkw(32'h77776666, 4'hF, 1'b1, 1'b0, 16'd8));
      wq.push_back(mkw(32'h55554444, 4'hF, 1'b0, 1'b1, 16'd8));
      evq.push_back(2'b10);
      send_pkt(16'd8, 1);
      drain("drain_after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/srio2udp_interface.md
Name: srio2udp_interface

Overview:
- Receive-side counterpart of the UDP-to-SRIO path.
- Takes packets delivered by the SRIO user interface as a 64-bit stream with first/last/keep and a byte length. Forwards them to the Ethernet UDP transmit path as a 32-bit stream with first/last/keep and length.
- Arbitrates for the UDP transmitter with a req/ack handshake, rejects packets whose length is illegal, and checks the byte count against the declared length.
- Sits in the UDP clock domain; any clock-domain crossing is done upstream.

Parameters:
- MAX_LEN, 16'd1472, largest accepted payload in bytes; a larger declared length is dropped.
- MIN_LEN, 16'd1, smallest accepted payload in bytes.

Ports:
- clk_udp  in  1  UDP-domain clock
- reset_udp  in  1  asynchronous active-high reset
- srio_data_in  in  64  payload; bits [63:32] go out first
- srio_valid_in  in  1  beat valid
- srio_first_in  in  1  first beat of packet
- srio_last_in  in  1  last beat of packet
- srio_keep_in  in  8  byte enables, MSB-first and contiguous; only partial on the last beat
- srio_length_in  in  16  packet length in bytes; valid with srio_first_in
- srio_ready_out  out  1  beat accepted when valid & ready
- udp_req_out  out  1  request for the UDP transmitter
- udp_ack_in  in  1  grant; single-cycle pulse
- udp_data_out  out  32  payload word
- udp_valid_out  out  1  word valid
- udp_first_out  out  1  first word
- udp_last_out  out  1  last word
- udp_keep_out  out  4  byte enables
- udp_length_out  out  16  latched packet length; stable from first to last
- udp_ready_in  in  1  downstream ready
- pkt_done_out  out  1  one-cycle pulse when the last word is accepted
- len_err_out  out  1  one-cycle pulse on length violation or byte-count mismatch

Behaviour:
- Reset values: every output is 0 and the state is IDLE.
- Reset asserted mid-packet: the packet is abandoned, req drops and nothing more is output.
- FSM states: IDLE, REQ, HI, LO, DROP.
- IDLE:
  - srio_ready_out=0.
  - On srio_valid_in & srio_first_in, latch srio_length_in.
  - If length <MIN_LEN or >MAX_LEN: pulse len_err_out, go to DROP.
  - Otherwise assert udp_req_out and go to REQ.
  - A valid beat without first in IDLE is consumed (ready=1) and discarded.
- REQ:
  - udp_req_out is held high until udp_ack_in.
  - On ack, req is deasserted and the held first beat is captured into a 64-bit holding register (srio_ready_out=1 for that cycle). Go to HI.
- HI:
  - Drives hold[63:32] and keep[7:4]; udp_first_out=1 on the first word of the packet only.
  - When udp_ready_in is high and hold_keep[3:0]!=0, go to LO.
  - Otherwise this word ends the beat; apply the end-of-beat rule.
- LO:
  - Drives hold[31:0] and keep[3:0].
  - When udp_ready_in is high, apply the end-of-beat rule.
- End-of-beat rule:
  - If the held beat was last: udp_last_out=1 on this word, pulse pkt_done_out, go to IDLE.
  - Otherwise assert srio_ready_out combinationally in the same cycle. If srio_valid_in, capture the next beat and go to HI with zero bubble; if not, stay with udp_valid_out=0 until a beat arrives.
  - Sustained rate is one 32-bit word per cycle.
- udp_valid_out stays high in HI/LO while data is held.
- Data, keep, first and last stay stable while valid & !ready.
- Byte counter (16-bit):
  - Adds popcount(keep) for each accepted SRIO beat.
  - At the last beat, total != latched length → pulse len_err_out in the same cycle as pkt_done_out.
  - The data is still forwarded unchanged.
- srio_first_in on a non-first beat is treated as data and pulses len_err_out.
- DROP: srio_ready_out=1, beats are discarded until srio_last_in is accepted, then go to IDLE. No req and no UDP output.
- A packet of one beat with keep=8'hF0 yields a single word with first=last=1.

Decomposition:
- Shared package srio_udp_pkg:
  - FSM state enum.
  - MAX_LEN/MIN_LEN defaults.
  - popcount8 function.
  - Byte-order constant (upper word first).
- Natural sub-module: srio2udp_width_conv, holding the 64→32 holding register and HI/LO sequencing. The top keeps the FSM, req/ack and the length checks.

Test Plan:
- Length 16, two full beats 0x0011223344556677 and 0x8899AABBCCDDEEFF, ack one cycle after req → four words 00112233 (first), 44556677, 8899AABB, CCDDEEFF (last), keep F each, udp_length_out=16, pkt_done_out pulses, no err.
- Length 12, second beat keep=F0 → three words; the last word has keep F and last=1; the LO half of the final beat is never driven.
- Length 2000 → len_err_out pulses, udp_req_out stays 0, all beats consumed via ready=1, the next legal packet is forwarded normally.
- Declared length 24 but 16 bytes sent → data forwarded; len_err_out and pkt_done_out pulse together.
- udp_ready_in toggled 50% randomly → outputs stay stable under backpressure; the byte stream matches the input exactly; no word is lost or duplicated.
- reset_udp asserted while in LO mid-packet → all outputs 0 next cycle; after release the next packet with first=1 is forwarded correctly.
